vc_input_buffer_route: RTL and testbench
========================================

// Module: vc_input_buffer_route
// PURPOSE
//  Per-input-port virtual-channel flit storage for the NoC router: num_vcs independent FIFOs
//  sharing one write port, with every VC's head flit exposed for allocation. A routing stage
//  computes a dimension-order (XY) output port for each VC head and for the selected flit.
//  Feeds VC/switch allocators; the crossbar consumes data_out.
// PARAMETERS
//  num_vcs        4   number of VCs (>=2)
//  buffer_length  8   flits per VC FIFO (power of 2, >=2)
//  data_width     32  payload bits
//  Flit (FW=data_width+num_vcs+15 bits, MSB->LSB): head(1) tail(1) vc_id(num_vcs, one-hot)
//    out_port(5) x_disp(4, signed) y_disp(4, signed) data(data_width)
// PORTS
//  clk               in   1          clock, rising edge
//  rst_n             in   1          synchronous reset, active low
//  push              in   1          write data_in into VC vc_id this edge
//  vc_id             in   clog2(num_vcs)  binary target VC for push
//  data_in           in   FW         incoming flit
//  pop               in   num_vcs    one-hot/multi-hot per-VC pop of head flit
//  select            in   num_vcs    one-hot VC whose head drives data_out
//  data_out          out  FW         routed head flit of selected VC
//  data_in_reg       out  FW         data_in registered
//  flit_buffer_out   out  num_vcs*FW head flit of each VC (VC i at [i*FW +: FW])
//  output_port       out  num_vcs*5  route of each VC head (one-hot N,E,S,W,L = bits 0..4)
//  head_is_tail      out  num_vcs    VC head has both head and tail set
//  flags             out  num_vcs*4  per VC {full,nearly_full,nearly_empty,empty}, VC i at [4i+:4]
//  buf_finished_empty out num_vcs    pulse: VC drained to empty last edge
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all VC pointers/occupancies 0; flags = empty=1,nearly_empty=1,
//    full=0,nearly_full=0; data_in_reg=0; buf_finished_empty=0. Storage contents not reset.
//  - Write: push=1 stores data_in at tail of VC vc_id on the edge; visible at head next cycle
//    if VC was empty (no fall-through; 1-cycle write-to-read latency).
//  - Read: pop[i]=1 removes head of VC i on the edge; several VCs may pop in one cycle.
//  - Same-VC push+pop same edge: both happen, occupancy unchanged; allowed even when full.
//  - Push to full VC without pop: flit dropped, occupancy unchanged (sim assertion error).
//    Pop of empty VC: ignored (sim assertion error).
//  - Flags registered, derived from next occupancy: empty=(occ==0), full=(occ==buffer_length),
//    nearly_empty=(occ<=1), nearly_full=(occ>=buffer_length-1).
//  - Pointers wrap modulo buffer_length; occupancy counter is clog2(buffer_length)+1 bits.
//  - flit_buffer_out[i] = head of VC i, combinational from storage; 0 when VC empty.
//  - head_is_tail[i] = ~empty & head.head & head.tail.
//  - Route (combinational per VC head): x_disp>0 -> E; x_disp<0 -> W; else y_disp>0 -> N;
//    y_disp<0 -> S; else L. output_port[i]=0 when VC i empty.
//  - data_out = AND-OR mux of flit_buffer_out by select, with out_port field replaced by the
//    route of that head; all other fields (incl. vc_id) passed unchanged. select=0 -> data_out=0.
//    Multi-hot select is illegal (assertion).
//  - data_in_reg <= data_in every cycle (independent of push).
//  - buf_finished_empty[i] registered: 1 for one cycle after an edge where VC i went from
//    occ==1 to occ==0 (pop without push); else 0.
// TESTING
//  - Reset: hold rst_n=0 2 cycles -> flags[i]=4'b0011 all VCs, output_port=0, data_out=0.
//  - Fill VC2 with 8 flits, push 9th -> full=1 after 8th, 9th dropped; pop 8 -> data order
//    0..7, empty=1 and buf_finished_empty[2] pulses once after last pop.
//  - Head x_disp=+2 in VC0, x_disp=0,y_disp=-1 in VC1, both 0 in VC3 -> output_port
//    VC0=E(00010), VC1=S(00100), VC3=L(10000); select=0010 -> data_out.out_port=00100.
//  - Full VC1, push+pop VC1 same edge -> occ stays 8, flit accepted, head advances.
//  - Single flit head=tail=1 in VC3 -> head_is_tail[3]=1; pop -> 0 next cycle.
//  - Concurrent pop on VC0 and VC2 with push to VC1 -> all three occupancies update correctly.

Source files
------------

// File: rtl/vc_input_buffer_route.sv
// vc_input_buffer_route
// Per-input-port virtual-channel flit storage for the NoC router. num_vcs independent FIFOs
// share one write port. Every VC's head flit is exposed for allocation, along with a
// dimension-order (XY) route for that head. The selected head is driven onto data_out with
// its out_port field rewritten to the computed route.
//
// Flit layout (MSB -> LSB):
//   head(1) tail(1) vc_id(num_vcs, one-hot) out_port(5) x_disp(4, signed) y_disp(4, signed) data
// Route encoding (one-hot): N=bit0, E=bit1, S=bit2, W=bit3, L=bit4.
//
// strict_checks enables simulation assertions that flag protocol misuse: pushing into a full
// VC without a pop, popping an empty VC, and a multi-hot select.
module vc_input_buffer_route #(
    parameter int num_vcs       = 4,
    parameter int buffer_length = 8,
    parameter int data_width    = 32,
    parameter bit strict_checks = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           push,
    input  logic [$clog2(num_vcs)-1:0]                     vc_id,
    input  logic [data_width+num_vcs+14:0]                 data_in,
    input  logic [num_vcs-1:0]                             pop,
    input  logic [num_vcs-1:0]                             select,
    output logic [data_width+num_vcs+14:0]                 data_out,
    output logic [data_width+num_vcs+14:0]                 data_in_reg,
    output logic [num_vcs*(data_width+num_vcs+15)-1:0]     flit_buffer_out,
    output logic [num_vcs*5-1:0]                           output_port,
    output logic [num_vcs-1:0]                             head_is_tail,
    output logic [num_vcs*4-1:0]                           flags,
    output logic [num_vcs-1:0]                             buf_finished_empty
);

    localparam int FW       = data_width + num_vcs + 15;
    localparam int VW       = $clog2(num_vcs);
    localparam int PW       = $clog2(buffer_length);
    localparam int OW       = PW + 1;
    localparam int Y_LSB    = data_width;
    localparam int X_LSB    = data_width + 4;
    localparam int PORT_LSB = data_width + 8;
    localparam int TAIL_BIT = data_width + num_vcs + 13;
    localparam int HEAD_BIT = data_width + num_vcs + 14;

    localparam logic [4:0] PORT_N = 5'b00001;
    localparam logic [4:0] PORT_E = 5'b00010;
    localparam logic [4:0] PORT_S = 5'b00100;
    localparam logic [4:0] PORT_W = 5'b01000;
    localparam logic [4:0] PORT_L = 5'b10000;

    logic [FW-1:0]      storage   [num_vcs][buffer_length];
    logic [PW-1:0]      wr_ptr    [num_vcs];
    logic [PW-1:0]      rd_ptr    [num_vcs];
    logic [OW-1:0]      occ       [num_vcs];
    logic [OW-1:0]      occ_next  [num_vcs];
    logic [FW-1:0]      head_flit [num_vcs];
    logic [4:0]         route     [num_vcs];
    logic [num_vcs-1:0] do_push;
    logic [num_vcs-1:0] do_pop;

    // Qualify requests: a pop needs a non-empty VC; a push needs room, or a same-edge pop
    // on that VC which frees a slot, so a full VC can still stream one-in/one-out.
    always_comb begin
        do_push = '0;
        do_pop  = '0;
        for (int v = 0; v < num_vcs; v++) begin
            do_pop[v]   = pop[v] && (occ[v] != '0);
            do_push[v]  = push && (vc_id == VW'(v)) &&
                          ((occ[v] != OW'(buffer_length)) || do_pop[v]);
            occ_next[v] = occ[v] + OW'(do_push[v]) - OW'(do_pop[v]);
        end
    end

    // Pointer, occupancy and status bookkeeping; flags are registered from the next occupancy
    // so they line up with the storage state visible in the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int v = 0; v < num_vcs; v++) begin
                wr_ptr[v]        <= '0;
                rd_ptr[v]        <= '0;
                occ[v]           <= '0;
                flags[4*v +: 4]  <= 4'b0011;
            end
            buf_finished_empty <= '0;
        end else begin
            for (int v = 0; v < num_vcs; v++) begin
                if (do_push[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PW'(1);
                end
                if (do_pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PW'(1);
                end
                occ[v]          <= occ_next[v];
                flags[4*v +: 4] <= {occ_next[v] == OW'(buffer_length),
                                    occ_next[v] >= OW'(buffer_length - 1),
                                    occ_next[v] <= OW'(1),
                                    occ_next[v] == '0};
                buf_finished_empty[v] <= do_pop[v] && !do_push[v] && (occ[v] == OW'(1));
            end
        end
    end

    // Free-running capture of the incoming flit, independent of push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_in_reg <= '0;
        end else begin
            data_in_reg <= data_in;
        end
    end

    // Flit storage is deliberately not reset; the empty qualification on the read side hides
    // stale contents.
    always_ff @(posedge clk) begin
        for (int v = 0; v < num_vcs; v++) begin
            if (do_push[v]) begin
                storage[v][wr_ptr[v]] <= data_in;
            end
        end
    end

    // Expose each VC head, compute its XY route (X resolved first), and build the
    // selected, route-stamped flit as an AND-OR mux so select=0 yields all zeros.
    always_comb begin
        logic signed [3:0] x_disp;
        logic signed [3:0] y_disp;
        logic [FW-1:0]     routed;
        data_out        = '0;
        flit_buffer_out = '0;
        output_port     = '0;
        head_is_tail    = '0;
        x_disp          = '0;
        y_disp          = '0;
        routed          = '0;
        for (int v = 0; v < num_vcs; v++) begin
            head_flit[v] = (occ[v] == '0) ? '0 : storage[v][rd_ptr[v]];
            x_disp       = head_flit[v][X_LSB +: 4];
            y_disp       = head_flit[v][Y_LSB +: 4];
            if (occ[v] == '0) begin
                route[v] = '0;
            end else if (x_disp > 4'sd0) begin
                route[v] = PORT_E;
            end else if (x_disp < 4'sd0) begin
                route[v] = PORT_W;
            end else if (y_disp > 4'sd0) begin
                route[v] = PORT_N;
            end else if (y_disp < 4'sd0) begin
                route[v] = PORT_S;
            end else begin
                route[v] = PORT_L;
            end
            flit_buffer_out[v*FW +: FW] = head_flit[v];
            output_port[v*5 +: 5]       = route[v];
            head_is_tail[v]             = (occ[v] != '0) && head_flit[v][HEAD_BIT] &&
                                          head_flit[v][TAIL_BIT];
            routed                      = head_flit[v];
            routed[PORT_LSB +: 5]       = route[v];
            data_out                    = data_out | ({FW{select[v]}} & routed);
        end
    end

    generate
        if (strict_checks) begin : g_checks
            a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
                !(push && (do_push == '0)))
                else $error("vc_input_buffer_route: push to full VC %0d dropped", vc_id);
            a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
                ((pop & ~do_pop) == '0))
                else $error("vc_input_buffer_route: pop of empty VC, pop=%b", pop);
            a_select_onehot: assert property (@(posedge clk) disable iff (!rst_n)
                $onehot0(select))
                else $error("vc_input_buffer_route: multi-hot select %b", select);
        end
    endgenerate

endmodule

// File: tb/tb_vc_input_buffer_route.sv
// tb_vc_input_buffer_route
// Self-checking bench for vc_input_buffer_route. A queue-per-VC reference model predicts every
// output each cycle; a vector table plus directed sequences cover routing, fill/drain, full
// streaming and concurrent operation, followed by randomized traffic. Protocol assertions are
// disabled in the DUT because the bench deliberately pushes into a full VC and pops empty VCs.
module tb_vc_input_buffer_route;

    localparam int NV       = 4;
    localparam int BL       = 8;
    localparam int DW       = 32;
    localparam int FW       = DW + NV + 15;
    localparam int PORT_LSB = DW + 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              push;
    logic [1:0]        vc_id;
    logic [FW-1:0]     data_in;
    logic [NV-1:0]     pop;
    logic [NV-1:0]     select;
    logic [FW-1:0]     data_out;
    logic [FW-1:0]     data_in_reg;
    logic [NV*FW-1:0]  flit_buffer_out;
    logic [NV*5-1:0]   output_port;
    logic [NV-1:0]     head_is_tail;
    logic [NV*4-1:0]   flags;
    logic [NV-1:0]     buf_finished_empty;

    logic [FW-1:0]     mq [NV][$];
    logic [FW-1:0]     mDinReg;
    logic [NV-1:0]     mBfe;
    int                checkCount = 0;
    int                errorCount = 0;

    typedef struct {
        bit          doPush;
        int          vc;
        bit          h;
        bit          t;
        int          x;
        int          y;
        logic [3:0]  pop;
        logic [3:0]  sel;
        logic [15:0] eFlags;
        logic [19:0] eRoute;
        logic [3:0]  eHit;
        logic [3:0]  eBfe;
        logic [4:0]  eOutPort;
    } vec_t;

    vec_t vecs [8];

    vc_input_buffer_route #(
        .num_vcs(NV),
        .buffer_length(BL),
        .data_width(DW),
        .strict_checks(1'b0)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .push(push),
        .vc_id(vc_id),
        .data_in(data_in),
        .pop(pop),
        .select(select),
        .data_out(data_out),
        .data_in_reg(data_in_reg),
        .flit_buffer_out(flit_buffer_out),
        .output_port(output_port),
        .head_is_tail(head_is_tail),
        .flags(flags),
        .buf_finished_empty(buf_finished_empty)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Backstop so the run always ends even if something stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [FW-1:0] mkFlit(input bit h, input bit t, input int vc, input int x,
                                             input int y, input logic [4:0] port,
                                             input logic [DW-1:0] d);
        logic [NV-1:0] oh;
        oh     = '0;
        oh[vc] = 1'b1;
        return {h, t, oh, port, 4'(x), 4'(y), d};
    endfunction

    function automatic logic [4:0] expRoute(input logic [FW-1:0] f);
        int x;
        int y;
        x = $signed(f[DW+4 +: 4]);
        y = $signed(f[DW +: 4]);
        if (x > 0) return 5'b00010;
        if (x < 0) return 5'b01000;
        if (y > 0) return 5'b00001;
        if (y < 0) return 5'b00100;
        return 5'b10000;
    endfunction

    task automatic checkVal(input string name, input logic [255:0] act, input logic [255:0] exp);
        checkCount++;
        if (act !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance the reference model across one clock edge using the inputs currently applied.
    task automatic modelEdge();
        logic [NV-1:0] popped;
        bit            accepted;
        if (!rst_n) begin
            for (int i = 0; i < NV; i++) mq[i].delete();
            mDinReg = '0;
            mBfe    = '0;
        end else begin
            mDinReg = data_in;
            popped  = '0;
            mBfe    = '0;
            for (int i = 0; i < NV; i++) begin
                if (pop[i] && mq[i].size() > 0) popped[i] = 1'b1;
            end
            for (int i = 0; i < NV; i++) begin
                accepted = push && (int'(vc_id) == i) && (mq[i].size() < BL || popped[i]);
                if (popped[i] && mq[i].size() == 1 && !accepted) mBfe[i] = 1'b1;
                if (popped[i]) void'(mq[i].pop_front());
                if (accepted) mq[i].push_back(data_in);
            end
        end
    endtask

    // Compare every DUT output against the model state.
    task automatic checkOutput();
        logic [NV*FW-1:0] eFbo;
        logic [NV*5-1:0]  ePort;
        logic [NV-1:0]    eHit;
        logic [NV*4-1:0]  eFlags;
        logic [FW-1:0]    eOut;
        logic [FW-1:0]    h;
        logic [FW-1:0]    r;
        int               n;
        eFbo   = '0;
        ePort  = '0;
        eHit   = '0;
        eFlags = '0;
        eOut   = '0;
        for (int i = 0; i < NV; i++) begin
            n = mq[i].size();
            h = (n > 0) ? mq[i][0] : '0;
            eFlags[4*i +: 4] = {n == BL, n >= BL - 1, n <= 1, n == 0};
            eFbo[i*FW +: FW] = h;
            if (n > 0) begin
                ePort[i*5 +: 5] = expRoute(h);
                eHit[i]         = h[FW-1] & h[FW-2];
                if (select[i]) begin
                    r                  = h;
                    r[PORT_LSB +: 5]   = expRoute(h);
                    eOut               = eOut | r;
                end
            end
        end
        checkVal("flags", flags, eFlags);
        checkVal("flit_buffer_out", flit_buffer_out, eFbo);
        checkVal("output_port", output_port, ePort);
        checkVal("head_is_tail", head_is_tail, eHit);
        checkVal("data_out", data_out, eOut);
        checkVal("data_in_reg", data_in_reg, mDinReg);
        checkVal("buf_finished_empty", buf_finished_empty, mBfe);
    endtask

    // Drive one cycle of inputs, step the model at the edge, then check just after it.
    task automatic applyStimulus(input bit p, input int v, input logic [FW-1:0] d,
                                 input logic [NV-1:0] po, input logic [NV-1:0] s);
        push    = p;
        vc_id   = 2'(v);
        data_in = d;
        pop     = po;
        select  = s;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput();
    endtask

    initial begin
        int            pulses;
        logic [63:0]   rr;
        logic [NV-1:0] pm;
        logic [NV-1:0] sm;
        int            popPct;

        vecs[0] = '{1'b1, 0, 1'b1, 1'b0,  2,  0, 4'b0000, 4'b0000, 16'h3332, 20'h00002, 4'b0000, 4'b0000, 5'b00000};
        vecs[1] = '{1'b1, 1, 1'b1, 1'b1,  0, -1, 4'b0000, 4'b0000, 16'h3322, 20'h00082, 4'b0010, 4'b0000, 5'b00000};
        vecs[2] = '{1'b1, 3, 1'b1, 1'b1,  0,  0, 4'b0000, 4'b0010, 16'h2322, 20'h80082, 4'b1010, 4'b0000, 5'b00100};
        vecs[3] = '{1'b0, 0, 1'b0, 1'b0,  0,  0, 4'b0000, 4'b0001, 16'h2322, 20'h80082, 4'b1010, 4'b0000, 5'b00010};
        vecs[4] = '{1'b0, 0, 1'b0, 1'b0,  0,  0, 4'b0000, 4'b1000, 16'h2322, 20'h80082, 4'b1010, 4'b0000, 5'b10000};
        vecs[5] = '{1'b0, 0, 1'b0, 1'b0,  0,  0, 4'b1000, 4'b1000, 16'h3322, 20'h00082, 4'b0010, 4'b1000, 5'b00000};
        vecs[6] = '{1'b0, 0, 1'b0, 1'b0,  0,  0, 4'b0011, 4'b0000, 16'h3333, 20'h00000, 4'b0000, 4'b0011, 5'b00000};
        vecs[7] = '{1'b0, 0, 1'b0, 1'b0,  0,  0, 4'b0000, 4'b0000, 16'h3333, 20'h00000, 4'b0000, 4'b0000, 5'b00000};

        rst_n = 1'b0;
        mDinReg = '0;
        mBfe = '0;
        $display("[TB] reset");
        applyStimulus(1'b1, 2, mkFlit(1, 1, 2, 3, 3, 5'b11111, 32'hDEAD_BEEF), 4'b1111, 4'b0100);
        applyStimulus(1'b1, 1, mkFlit(1, 0, 1, 1, 1, 5'b10101, 32'hCAFE_F00D), 4'b0000, 4'b0010);
        checkVal("reset_flags", flags, 16'h3333);
        checkVal("reset_output_port", output_port, 20'h0);
        checkVal("reset_data_out", data_out, '0);
        rst_n = 1'b1;

        $display("[TB] routing vector table");
        for (int r = 0; r < 8; r++) begin
            applyStimulus(vecs[r].doPush, vecs[r].vc,
                          mkFlit(vecs[r].h, vecs[r].t, vecs[r].vc, vecs[r].x, vecs[r].y,
                                 5'b11111, 32'hA000_0000 + 32'(r)),
                          vecs[r].pop, vecs[r].sel);
            checkVal("vec_flags", flags, vecs[r].eFlags);
            checkVal("vec_route", output_port, vecs[r].eRoute);
            checkVal("vec_head_is_tail", head_is_tail, vecs[r].eHit);
            checkVal("vec_finished_empty", buf_finished_empty, vecs[r].eBfe);
            checkVal("vec_out_port", data_out[PORT_LSB +: 5], vecs[r].eOutPort);
        end

        $display("[TB] fill and drain VC2");
        for (int k = 0; k < BL; k++) begin
            applyStimulus(1'b1, 2, mkFlit(1, 0, 2, -3, 2, 5'b00000, 32'(k)), 4'b0000, 4'b0100);
        end
        checkVal("fill_full", flags[11:8], 4'b1100);
        applyStimulus(1'b1, 2, mkFlit(1, 0, 2, 1, 0, 5'b00000, 32'd99), 4'b0000, 4'b0100);
        checkVal("overflow_still_full", flags[11:8], 4'b1100);
        pulses = 0;
        for (int k = 0; k < BL; k++) begin
            checkVal("drain_order", flit_buffer_out[2*FW +: DW], 32'(k));
            applyStimulus(1'b0, 0, '0, 4'b0100, 4'b0100);
            pulses += int'(buf_finished_empty[2]);
        end
        checkVal("drain_empty", flags[11:8], 4'b0011);
        checkVal("drain_finished_pulse", buf_finished_empty, 4'b0100);
        applyStimulus(1'b0, 0, '0, 4'b0000, 4'b0000);
        pulses += int'(buf_finished_empty[2]);
        checkVal("finished_single_pulse", pulses, 1);

        $display("[TB] full VC1 streaming");
        for (int k = 16; k < 24; k++) begin
            applyStimulus(1'b1, 1, mkFlit(0, 0, 1, 0, 1, 5'b00000, 32'(k)), 4'b0000, 4'b0010);
        end
        applyStimulus(1'b1, 1, mkFlit(0, 1, 1, 0, 1, 5'b00000, 32'd24), 4'b0010, 4'b0010);
        checkVal("stream_full", flags[7:4], 4'b1100);
        checkVal("stream_head", flit_buffer_out[FW +: DW], 32'd17);
        for (int k = 17; k < 25; k++) begin
            checkVal("stream_order", flit_buffer_out[FW +: DW], 32'(k));
            applyStimulus(1'b0, 0, '0, 4'b0010, 4'b0010);
        end

        $display("[TB] concurrent pops with push");
        applyStimulus(1'b1, 0, mkFlit(1, 0, 0, 0, 5, 5'b00000, 32'd40), 4'b0000, 4'b0000);
        applyStimulus(1'b1, 0, mkFlit(0, 1, 0, 0, 5, 5'b00000, 32'd41), 4'b0000, 4'b0000);
        applyStimulus(1'b1, 2, mkFlit(1, 1, 2, -1, 0, 5'b00000, 32'd50), 4'b0000, 4'b0000);
        applyStimulus(1'b1, 1, mkFlit(1, 1, 1, 0, -6, 5'b00000, 32'd60), 4'b0101, 4'b0001);
        checkVal("concurrent_vc0", flags[3:0], 4'b0010);
        checkVal("concurrent_vc1", flags[7:4], 4'b0010);
        checkVal("concurrent_vc2", flags[11:8], 4'b0011);
        checkVal("concurrent_finished", buf_finished_empty, 4'b0100);
        checkVal("concurrent_vc0_head", flit_buffer_out[DW-1:0], 32'd41);
        applyStimulus(1'b0, 0, '0, 4'b0011, 4'b0000);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 400; c++) begin
            if (c == 200) rst_n = 1'b0;
            if (c == 202) rst_n = 1'b1;
            popPct = (c < 100) ? 10 : 40;
            pm = '0;
            for (int i = 0; i < NV; i++) pm[i] = ($urandom_range(0, 99) < popPct);
            sm = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'(1 << $urandom_range(0, 3));
            rr = {$urandom, $urandom};
            applyStimulus($urandom_range(0, 99) < 60, int'($urandom_range(0, 3)),
                          rr[FW-1:0], pm, sm);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
